// File: rtl/axis_pkt_framer.sv
// AXI-Stream byte packetizer. Packets close when the source marks tlast, when
// MAX_PKT_LEN bytes have been collected, on flush_i, or (when the
// PKT_FRAMER_TIMEOUT_EN macro is defined) after TIMEOUT_CYCLES idle cycles.
// One byte is always held back in H so the framer can still set tlast on it
// when the close reason arrives after that byte.
module axis_pkt_framer #(
  parameter int unsigned MAX_PKT_LEN    = 512,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        sys_clk,
  input  logic        reset_n,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tlast,
  input  logic        flush_i,
  output logic [15:0] pkt_count_o
);

  localparam int unsigned DW  = 8;
  localparam int unsigned CW  = $clog2(MAX_PKT_LEN + 1);
  localparam int unsigned PCW = 16;

  // Reject out-of-range configurations at elaboration
  if (MAX_PKT_LEN < 2 || MAX_PKT_LEN > 1024 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_cfg_err
    $error("axis_pkt_framer: parameter out of range");
  end

  // EMPTY: H empty; HOLD: H holds a mid-packet byte; CLOSE: H holds a last byte
  typedef enum logic [1:0] {EMPTY, HOLD, CLOSE} state_t;

  state_t         state_q, state_d;
  logic [DW-1:0]  hdata_q, hdata_d;
  logic [CW-1:0]  byte_cnt_q, byte_cnt_d;
  logic           o_valid_q, o_valid_d;
  logic [DW-1:0]  o_data_q, o_data_d;
  logic           o_last_q, o_last_d;
  logic [PCW-1:0] pkt_cnt_q;

  logic o_free_c;
  logic accept_c;
  logic new_last_c;
  logic timeout_hit_c;

  // Handshake qualifiers; the incoming byte is the (byte_cnt_q+1)-th of its packet
  assign o_free_c      = !o_valid_q || m_axis_tready;
  assign s_axis_tready = (state_q == EMPTY) || o_free_c;
  assign accept_c      = s_axis_tvalid && s_axis_tready;
  assign new_last_c    = s_axis_tlast || (byte_cnt_q == CW'(MAX_PKT_LEN - 1));

`ifdef PKT_FRAMER_TIMEOUT_EN
  localparam int unsigned TW = 16;
  logic [TW-1:0] idle_q;
  logic          timer_run_c;

  assign timeout_hit_c = (idle_q == TW'(TIMEOUT_CYCLES));
  assign timer_run_c   = (state_q == HOLD) && !accept_c &&
                         !(o_free_c && (timeout_hit_c || flush_i));

  // Idle timer: counts stalled HOLD cycles, saturates, clears otherwise
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_q <= '0;
    end else if (timer_run_c) begin
      if (!timeout_hit_c) idle_q <= idle_q + TW'(1);
    end else begin
      idle_q <= '0;
    end
  end
`else
  assign timeout_hit_c = 1'b0;
`endif

  // Next-state: move H to O and/or load a new byte into H
  always_comb begin
    state_d    = state_q;
    hdata_d    = hdata_q;
    byte_cnt_d = byte_cnt_q;
    o_valid_d  = o_valid_q && !m_axis_tready;
    o_data_d   = o_data_q;
    o_last_d   = o_last_q;

    case (state_q)
      EMPTY: begin
        if (accept_c) begin
          hdata_d    = s_axis_tdata;
          state_d    = new_last_c ? CLOSE : HOLD;
          byte_cnt_d = new_last_c ? '0 : byte_cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (accept_c) begin
          o_valid_d  = 1'b1;
          o_data_d   = hdata_q;
          o_last_d   = 1'b0;
          hdata_d    = s_axis_tdata;
          state_d    = new_last_c ? CLOSE : HOLD;
          byte_cnt_d = new_last_c ? '0 : byte_cnt_q + CW'(1);
        end else if (o_free_c && (timeout_hit_c || flush_i)) begin
          o_valid_d  = 1'b1;
          o_data_d   = hdata_q;
          o_last_d   = 1'b1;
          state_d    = EMPTY;
          byte_cnt_d = '0;
        end
      end
      CLOSE: begin
        if (o_free_c) begin
          o_valid_d = 1'b1;
          o_data_d  = hdata_q;
          o_last_d  = 1'b1;
          if (accept_c) begin
            hdata_d    = s_axis_tdata;
            state_d    = new_last_c ? CLOSE : HOLD;
            byte_cnt_d = new_last_c ? '0 : byte_cnt_q + CW'(1);
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: begin
        state_d    = EMPTY;
        byte_cnt_d = '0;
      end
    endcase
  end

  // State, hold and output registers plus the emitted-packet counter
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= EMPTY;
      hdata_q    <= '0;
      byte_cnt_q <= '0;
      o_valid_q  <= 1'b0;
      o_data_q   <= '0;
      o_last_q   <= 1'b0;
      pkt_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      hdata_q    <= hdata_d;
      byte_cnt_q <= byte_cnt_d;
      o_valid_q  <= o_valid_d;
      o_data_q   <= o_data_d;
      o_last_q   <= o_last_d;
      if (o_valid_q && m_axis_tready && o_last_q) pkt_cnt_q <= pkt_cnt_q + PCW'(1);
    end
  end

  assign m_axis_tvalid = o_valid_q;
  assign m_axis_tdata  = o_data_q;
  assign m_axis_tlast  = o_last_q;
  assign pkt_count_o   = pkt_cnt_q;

endmodule

// File: tb/tb_axis_pkt_framer.sv
// Testbench for axis_pkt_framer: directed scenarios plus randomized traffic
// scored against a byte-queue reference model of the packetization rules.
module tb_axis_pkt_framer;

  localparam int unsigned MAX_LEN = 512;
  localparam int unsigned TO_CYC  = 16;

  logic        sys_clk = 1'b0;
  logic        reset_n;
  logic        s_valid, s_ready, s_last;
  logic [7:0]  s_data;
  logic        m_valid, m_last;
  logic        m_ready = 1'b1;
  logic [7:0]  m_data;
  logic        flush;
  logic [15:0] pkt_count;

  axis_pkt_framer #(.MAX_PKT_LEN(MAX_LEN), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .sys_clk       (sys_clk),
    .reset_n       (reset_n),
    .s_axis_tvalid (s_valid),
    .s_axis_tready (s_ready),
    .s_axis_tdata  (s_data),
    .s_axis_tlast  (s_last),
    .m_axis_tvalid (m_valid),
    .m_axis_tready (m_ready),
    .m_axis_tdata  (m_data),
    .m_axis_tlast  (m_last),
    .flush_i       (flush),
    .pkt_count_o   (pkt_count)
  );

  always #5 sys_clk = ~sys_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: expected {last,data} per byte, open-packet byte count
  logic [8:0] exp_q[$];
  int         mcnt = 0;
  int         exp_pkts = 0;
  int         out_bytes = 0;
  int         lastpos[$];
  int         cyc = 0;
  int         last_acc_cyc = 0;
  int         ready_mode = 0;

  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Sink ready pattern: 0 always, 1 toggle, 2 random, 3 never
  always @(posedge sys_clk) begin
    #1;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ~m_ready;
      2:       m_ready = ($urandom_range(0, 3) != 0);
      default: m_ready = 1'b0;
    endcase
  end

  // Monitor: stability, output scoring, and model updates on accepted input
  always @(negedge sys_clk) begin
    logic [8:0] e;
    logic       acc;
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(m_valid), 32'd1);
        check("stall_data", 32'(m_data), 32'(prev_data));
        check("stall_last", 32'(m_last), 32'(prev_last));
      end
      if (m_valid && m_ready) begin
        check("out_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_data", 32'(m_data), 32'(e[7:0]));
          check("out_last", 32'(m_last), 32'(e[8]));
          if (e[8]) exp_pkts++;
        end
        if (m_last) lastpos.push_back(out_bytes);
        out_bytes++;
      end
      acc = s_valid && s_ready;
      if (acc) begin
        e[7:0] = s_data;
        e[8]   = s_last || (mcnt + 1 == int'(MAX_LEN));
        exp_q.push_back(e);
        mcnt = e[8] ? 0 : mcnt + 1;
        last_acc_cyc = cyc + 1;
      end
      if (flush && !acc && (!m_valid || m_ready) && mcnt != 0) begin
        exp_q[exp_q.size() - 1][8] = 1'b1;
        mcnt = 0;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    forever begin
      @(negedge sys_clk);
      if (s_ready || n > 2000) break;
      n++;
    end
    check("send_accept", 32'(s_ready), 32'd1);
    @(posedge sys_clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge sys_clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 5000) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int vcnt;
    int lat;
    reset_n = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    flush   = 1'b0;

    // Reset values
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_pkt_count", 32'(pkt_count), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    #2 reset_n = 1'b1;
    idle(2);

    // 1024 contiguous bytes, no tlast: two max-length packets
    base = out_bytes;
    lastpos.delete();
    for (int i = 0; i < 1024; i++) send_byte(8'(i), 1'b0);
    drain();
    check("maxlen_bytes", 32'(out_bytes - base), 32'd1024);
    check("maxlen_npkt", 32'(lastpos.size()), 32'd2);
    if (lastpos.size() == 2) begin
      check("maxlen_last0", 32'(lastpos[0] - base), 32'd511);
      check("maxlen_last1", 32'(lastpos[1] - base), 32'd1023);
    end
    check("maxlen_pkt_count", 32'(pkt_count), 32'd2);

    // Source tlast on the 5th byte with a toggling sink
    ready_mode = 1;
    for (int i = 0; i < 5; i++) send_byte(8'(8'h30 + i), i == 4);
    drain();
    ready_mode = 0;
    idle(2);
    check("tlast5_pkt_count", 32'(pkt_count), 32'd3);

    // Two bytes then a one-cycle flush
    send_byte(8'h41, 1'b0);
    send_byte(8'h42, 1'b0);
    idle(5);
    check("flush_pre_count", 32'(pkt_count), 32'd3);
    do_flush();
    drain();
    check("flush_pkt_count", 32'(pkt_count), 32'd4);

    // Flush while empty produces nothing
    do_flush();
    vcnt = 0;
    repeat (10) begin
      @(negedge sys_clk);
      if (m_valid) vcnt++;
    end
    check("flush_empty_valid", 32'(vcnt), 32'd0);
    check("flush_empty_count", 32'(pkt_count), 32'd4);
    idle(1);

`ifdef PKT_FRAMER_TIMEOUT_EN
    // Three bytes then idle: timeout closes the packet
    send_byte(8'h51, 1'b0);
    send_byte(8'h52, 1'b0);
    send_byte(8'h53, 1'b0);
    exp_q[exp_q.size() - 1][8] = 1'b1;
    mcnt = 0;
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge sys_clk);
      if (m_valid && m_last) begin
        lat = cyc - last_acc_cyc;
        break;
      end
    end
    check("timeout_latency", 32'(lat), 32'd17);
    drain();
    check("timeout_pkt_count", 32'(pkt_count), 32'd5);
`else
    // Without the timer a lone byte waits indefinitely
    send_byte(8'h61, 1'b0);
    vcnt = 0;
    repeat (5000) begin
      @(negedge sys_clk);
      if (m_valid) vcnt++;
    end
    check("notimer_idle_valid", 32'(vcnt), 32'd0);
    idle(1);
    send_byte(8'h62, 1'b0);
    idle(3);
    check("notimer_first_count", 32'(pkt_count), 32'd4);
    do_flush();
    drain();
    check("notimer_pkt_count", 32'(pkt_count), 32'd5);
    lat = 0;
`endif

    // Reset with a byte held in H and O stalled
    ready_mode = 3;
    idle(2);
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0);
    idle(2);
    check("rst_mid_pre_valid", 32'(m_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(m_valid), 32'd0);
    check("rst_mid_count", 32'(pkt_count), 32'd0);
    exp_q.delete();
    mcnt = 0;
    exp_pkts = 0;
    ready_mode = 0;
    @(posedge sys_clk);
    #3 reset_n = 1'b1;
    idle(2);
    for (int i = 0; i < 4; i++) send_byte(8'(8'hB0 + i), i == 3);
    drain();
    check("rst_after_count", 32'(pkt_count), 32'd1);

    // Randomized traffic scored by the model
`ifdef PKT_FRAMER_TIMEOUT_EN
    ready_mode = 0;
`else
    ready_mode = 2;
`endif
    for (int i = 0; i < 1500; i++) begin
      send_byte(8'($urandom), $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    ready_mode = 0;
    idle(3);
    do_flush();
    drain();
    idle(2);
    check("rand_pkt_count", 32'(pkt_count), 32'(exp_pkts));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
